// File: rtl/mx_fpga_id_pkg.sv
// Shared types and constants for the FPGA ID ROM sequencer.
// Holds the FSM state encoding, the ROM port widths and the default magic word.
package mx_fpga_id_pkg;

  localparam int          ROM_AW        = 8;
  localparam int          ROM_DW        = 32;
  localparam int          CNT_W         = 4;
  localparam int          IDX_W         = 4;
  localparam logic [31:0] MAGIC_DEFAULT = 32'h4D58_4944;

  typedef enum logic [2:0] {
    SCAN_ADDR = 3'd0,
    SCAN_WAIT = 3'd1,
    SCAN_CAP  = 3'd2,
    READY     = 3'd3,
    HOST_WAIT = 3'd4,
    HOST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/mx_fpga_id_lat_cnt.sv
// Loadable down-counter timing the ROM read latency for both scan and host reads.
// done_o flags the cycle in which the count steps from 1 to 0.
module mx_fpga_id_lat_cnt
  import mx_fpga_id_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/mx_fpga_id_rom_ctrl.sv
// FPGA ID ROM sequencer: post-reset scan of magic and option words, then host read arbitration.
// Optional trailing checksum word over the option mask when MX_FPGA_ID_OPT_CHECKSUM_EN is defined.
//
// state     | meaning
// SCAN_ADDR | scan address on the port, latency counter loaded
// SCAN_WAIT | waiting for scan read data
// SCAN_CAP  | capture magic / option / checksum word
// READY     | idle; serves rescan first, then host requests
// HOST_WAIT | host address on the port, waiting for data
// HOST_DONE | ack cycle; lets the requester drop req
module mx_fpga_id_rom_ctrl
  import mx_fpga_id_pkg::*;
#(
  parameter int          ROM_LAT    = 2,
  parameter logic [7:0]  OPT_BASE   = 8'h04,
  parameter int          OPT_WORDS  = 2,
  parameter logic [7:0]  MAGIC_ADDR = 8'h00,
  parameter logic [31:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic [ROM_AW-1:0]           rom_rd_addr_o,
  input  logic [ROM_DW-1:0]           rom_rd_data_i,
  input  logic                        host_req_i,
  input  logic [ROM_AW-1:0]           host_addr_i,
  output logic                        host_ack_o,
  output logic [ROM_DW-1:0]           host_data_o,
  input  logic                        rescan_i,
  output logic [ROM_DW*OPT_WORDS-1:0] options_o,
  output logic                        options_valid_o,
  output logic                        id_ok_o,
  output logic                        busy_o
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
  ,
  output logic                        chk_err_o
`endif
);

`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
  localparam int LAST_IDX = OPT_WORDS + 1;
`else
  localparam int LAST_IDX = OPT_WORDS;
`endif

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [ROM_AW-1:0]             addr_q, addr_d;
  logic                          ack_q, ack_d;
  logic [ROM_DW-1:0]             hdata_q, hdata_d;
  logic [ROM_DW*OPT_WORDS-1:0]   opts_q, opts_d;
  logic                          valid_q, valid_d;
  logic                          id_ok_q, id_ok_d;
  logic                          busy_q, busy_d;
  logic                          pend_q, pend_d;
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
  logic                          chk_err_q, chk_err_d;
  logic [ROM_DW-1:0]             opt_xor;
`endif

  logic                          cnt_load;
  logic [CNT_W-1:0]              cnt_load_val;
  logic                          cnt_dec;
  logic [CNT_W-1:0]              cnt_val;
  logic                          cnt_done;

  mx_fpga_id_lat_cnt #(.W(CNT_W)) u_lat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .done_o     (cnt_done)
  );

  function automatic logic [ROM_AW-1:0] scan_addr(input logic [IDX_W-1:0] idx);
    if (idx == '0) begin
      return MAGIC_ADDR;
    end
    return OPT_BASE + ROM_AW'(idx) - ROM_AW'(1);
  endfunction

`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
  always_comb begin
    opt_xor = '0;
    for (int k = 0; k < OPT_WORDS; k++) begin
      opt_xor = opt_xor ^ opts_q[k*ROM_DW +: ROM_DW];
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SCAN_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN_ADDR: state_d = (ROM_LAT == 1) ? SCAN_CAP : SCAN_WAIT;
      SCAN_WAIT: if (cnt_done) state_d = SCAN_CAP;
      SCAN_CAP:  state_d = (idx_q == IDX_W'(LAST_IDX)) ? READY : SCAN_ADDR;
      READY: begin
        if (rescan_i || pend_q) begin
          state_d = SCAN_ADDR;
        end else if (host_req_i) begin
          state_d = HOST_WAIT;
        end
      end
      HOST_WAIT: if (cnt_done) state_d = HOST_DONE;
      HOST_DONE: state_d = READY;
      default:   state_d = SCAN_ADDR;
    endcase
  end

  // Next values of the registered outputs; the ROM address is set on entry to a read state.
  always_comb begin
    idx_d        = idx_q;
    addr_d       = addr_q;
    ack_d        = 1'b0;
    hdata_d      = hdata_q;
    opts_d       = opts_q;
    valid_d      = valid_q;
    id_ok_d      = id_ok_q;
    pend_d       = pend_q | (rescan_i && (state_q != READY));
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
    chk_err_d    = chk_err_q;
`endif
    case (state_q)
      SCAN_ADDR: begin
        cnt_load     = 1'b1;
        cnt_load_val = CNT_W'(ROM_LAT - 1);
      end
      SCAN_WAIT: cnt_dec = 1'b1;
      SCAN_CAP: begin
        if (idx_q == '0) begin
          id_ok_d = (rom_rd_data_i == MAGIC);
        end
        for (int k = 0; k < OPT_WORDS; k++) begin
          if (idx_q == IDX_W'(k + 1)) begin
            opts_d[k*ROM_DW +: ROM_DW] = rom_rd_data_i;
          end
        end
        if (idx_q == IDX_W'(LAST_IDX)) begin
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
          if (rom_rd_data_i == opt_xor) begin
            valid_d = 1'b1;
          end else begin
            opts_d    = '0;
            chk_err_d = 1'b1;
          end
`else
          valid_d = 1'b1;
`endif
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = scan_addr(idx_q + IDX_W'(1));
        end
      end
      READY: begin
        if (rescan_i || pend_q) begin
          valid_d = 1'b0;
          idx_d   = '0;
          addr_d  = MAGIC_ADDR;
          pend_d  = 1'b0;
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
          chk_err_d = 1'b0;
`endif
        end else if (host_req_i) begin
          addr_d       = host_addr_i;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(ROM_LAT + 1);
        end
      end
      HOST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          hdata_d = rom_rd_data_i;
          ack_d   = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != READY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      addr_q    <= MAGIC_ADDR;
      ack_q     <= 1'b0;
      hdata_q   <= '0;
      opts_q    <= '0;
      valid_q   <= 1'b0;
      id_ok_q   <= 1'b0;
      busy_q    <= 1'b1;
      pend_q    <= 1'b0;
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
      chk_err_q <= 1'b0;
`endif
    end else begin
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      hdata_q   <= hdata_d;
      opts_q    <= opts_d;
      valid_q   <= valid_d;
      id_ok_q   <= id_ok_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign rom_rd_addr_o   = addr_q;
  assign host_ack_o      = ack_q;
  assign host_data_o     = hdata_q;
  assign options_o       = opts_q;
  assign options_valid_o = valid_q;
  assign id_ok_o         = id_ok_q;
  assign busy_o          = busy_q;
`ifdef MX_FPGA_ID_OPT_CHECKSUM_EN
  assign chk_err_o       = chk_err_q;
`endif

endmodule

// File: doc/mx_fpga_id_rom_ctrl.md
Name: mx_fpga_id_rom_ctrl

Overview:
- Sequencer and arbiter for the FPGA ID ROM read port (8-bit word address, 32-bit read data, fixed read latency).
- After reset it autonomously scans the ROM:
  - checks the ID magic word;
  - loads the enabled-options bitmask into a shadow register for fabric consumers.
- After the scan it serves single-word host reads through a req/ack handshake and arbitrates the ROM port between rescan and host.
- Sits between the ROM and the CSR/option-gating logic of the feature blocks.

Parameters:
- ROM_LAT, 2, ROM read latency in cycles from address to data (1..7).
- OPT_BASE, 8'h04, ROM address of the first option-mask word.
- OPT_WORDS, 2, number of 32-bit option-mask words (1..8).
- MAGIC_ADDR, 8'h00, ROM address of the ID magic word.
- MAGIC, 32'h4D58_4944, expected magic value.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- rom_rd_addr_o  out  8  ROM read address.
- rom_rd_data_i  in  32  ROM read data; valid ROM_LAT cycles after the address.
- host_req_i  in  1  host read request, level; held until ack.
- host_addr_i  in  8  host word address; stable while req is high.
- host_ack_o  out  1  one-cycle ack pulse.
- host_data_o  out  32  read data; valid in the ack cycle, held until the next ack.
- rescan_i  in  1  pulse; requests a full re-scan.
- options_o  out  32*OPT_WORDS  option bitmask; word k is ROM[OPT_BASE+k].
- options_valid_o  out  1  high when options_o reflects a completed scan.
- id_ok_o  out  1  high when the magic word matched on the last scan.
- busy_o  out  1  high in any state other than READY.

Behaviour:
- Interface: single clock clk_i; reset rst_i is synchronous and active-high. All outputs are registered.
- Reset values:
  - rom_rd_addr_o = MAGIC_ADDR;
  - host_ack_o, options_valid_o, id_ok_o = 0;
  - options_o, host_data_o = 0;
  - busy_o = 1;
  - state = SCAN_ADDR, scan index = 0.
- Scan sequence: MAGIC_ADDR, then OPT_BASE .. OPT_BASE+OPT_WORDS-1.
- States:
  - SCAN_ADDR: drive the address of the current scan index and load wait counter = ROM_LAT-1. Go to SCAN_WAIT, or SCAN_CAP if ROM_LAT == 1.
  - SCAN_WAIT: decrement the counter; at 0 go to SCAN_CAP.
  - SCAN_CAP:
    - index 0: id_ok_o <= (rom_rd_data_i == MAGIC);
    - index k > 0: options word k-1 <= rom_rd_data_i.
    - Last index: set options_valid_o and go to READY. Otherwise increment the index and go to SCAN_ADDR.
  - READY:
    - rescan_i has priority over host_req_i: clear options_valid_o (options_o and id_ok_o keep their old values until overwritten), index = 0, go to SCAN_ADDR.
    - Otherwise, on host_req_i: latch host_addr_i into rom_rd_addr_o, load the counter, go to HOST_WAIT.
  - HOST_WAIT: count ROM_LAT cycles, then capture rom_rd_data_i into host_data_o, pulse host_ack_o, go to HOST_DONE.
  - HOST_DONE: one cycle, so that the requester can drop req; go to READY. A request still high here is treated as a new request in READY.
- Host read latency: ack arrives ROM_LAT+2 cycles after req is sampled high in READY.
- A host request arriving during a scan waits (no ack) until READY.
- rescan_i while not in READY: latched into a pending flag, served at the next READY entry before any host request. Multiple pulses collapse into one.
- Reset mid-scan or mid-host read: abort immediately, no ack, values as listed above, full scan restarts.
- Full scan duration: (OPT_WORDS+1)*(ROM_LAT+1) cycles from reset release to options_valid_o = 1.

Optional Feature:
- Macro MX_FPGA_ID_OPT_CHECKSUM_EN.
- Defined:
  - The scan reads one extra word at OPT_BASE+OPT_WORDS.
  - options_valid_o is set only if that word equals the XOR of all option words.
  - On mismatch, options_o is forced to 0, options_valid_o stays 0, and the added output chk_err_o is 1 (cleared at the next scan start).
- Undefined: no extra read, no chk_err_o port.

Decomposition:
- Package mx_fpga_id_pkg:
  - state enum typedef (SCAN_ADDR, SCAN_WAIT, SCAN_CAP, READY, HOST_WAIT, HOST_DONE);
  - ROM address width 8 and data width 32 constants;
  - default MAGIC constant.
- Sub-module mx_fpga_id_lat_cnt: a loadable down-counter with a done flag, shared by the scan and host paths.

Test Plan:
- Reset release, ROM_LAT=2, ROM[0]=32'h4D58_4944, ROM[4]=32'h0000_00A5, ROM[5]=32'h8000_0001 -> after 9 cycles id_ok_o=1, options_valid_o=1, options_o=64'h8000_0001_0000_00A5, busy_o=0.
- ROM[0]=32'hDEAD_BEEF -> id_ok_o=0; options still loaded and options_valid_o=1.
- In READY, host_req_i with addr 8'h10 (ROM[16]=32'h1234_5678) -> host_ack_o pulse 4 cycles later with host_data_o=32'h1234_5678, a single pulse only.
- rescan_i and host_req_i in the same READY cycle -> scan runs first (options_valid_o drops to 0 and then returns); the host ack follows the scan; no lost request.
- rst_i asserted during HOST_WAIT -> no ack, outputs at reset values next cycle, fresh scan completes.
- Checksum enabled, ROM[6]=32'h8000_00A4 -> options_valid_o=1, chk_err_o=0. With ROM[6]=0 -> options_o=0, chk_err_o=1.
